// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Purpose:
//   Buffers ALU result triples (carry, result, branch flag) that come out of the
//   ALU output register stage. The triples go to the writeback / PC-update stage
//   over a valid/ready handshake. This lets the ALU keep issuing while writeback
//   is stalled. The buffer is circular with DEPTH entries. The head entry is
//   always driven on the outputs (first-word fall-through).
//
// Configuration macro:
//   BRANCH_FLUSH_EN - when defined, popping an entry whose branch flag is set
//                     also squashes every younger entry, including a push in
//                     the same cycle. This models the wrong-path squash after a
//                     taken branch. When undefined, the branch flag is plain
//                     data and a pop removes exactly one entry.
//
// Ports:
//   clk_i          in   1                 single clock, rising edge
//   sync_reset_i   in   1                 synchronous, active-low reset
//   in_valid_i     in   1                 upstream offers a result triple
//   in_ready_o     out  1                 buffer not full
//   c_i            in   1                 carry flag
//   salida_i       in   DATA_W            ALU result
//   branch_flag_i  in   1                 branch condition
//   out_valid_o    out  1                 head entry valid (not empty)
//   out_ready_i    in   1                 downstream takes the head entry
//   c_o            out  1                 head carry
//   salida_o       out  DATA_W            head result
//   branch_flag_o  out  1                 head branch flag
//   flush_i        in   1                 discard all entries
//   count_o        out  $clog2(DEPTH)+1   number of stored entries
//   overflow_o     out  1                 sticky: push attempted while full
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       sync_reset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       c_i,
    input  logic [DATA_W-1:0]          salida_i,
    input  logic                       branch_flag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       c_o,
    output logic [DATA_W-1:0]          salida_o,
    output logic                       branch_flag_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // The three fields are stored side by side. All three are indexed by the
    // same pointers.
    logic              mem_c      [DEPTH];
    logic [DATA_W-1:0] mem_salida [DEPTH];
    logic              mem_branch [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    logic              push;
    logic              pop;
    logic              branch_squash;

    // Full and empty are taken from the registered count. This keeps both
    // handshake outputs glitch-free and independent of same-cycle inputs.
    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // The head entry is always presented. It only changes on a pop, a flush or
    // a reset, so it stays stable while the consumer stalls.
    assign c_o           = mem_c[rd_ptr];
    assign salida_o      = mem_salida[rd_ptr];
    assign branch_flag_o = mem_branch[rd_ptr];

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Decide whether the entry leaving this cycle squashes the younger entries.
    // When the feature is compiled out, the branch flag is just carried data.
    always_comb begin
        branch_squash = 1'b0;
`ifdef BRANCH_FLUSH_EN
        branch_squash = pop & mem_branch[rd_ptr];
`else
        branch_squash = 1'b0;
`endif
    end

    // Pointer, count and overflow bookkeeping.
    // Priority order: reset, then flush / branch squash, then normal traffic.
    // The count is tracked separately from the pointers, because equal
    // pointers are ambiguous between full and empty.
    always_ff @(posedge clk_i) begin
        if (!sync_reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (in_valid_i && !in_ready_o) begin
                overflow_q <= 1'b1;
            end

            if (flush_i || branch_squash) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage writes. Reset clears the array, so the outputs read zero while
    // the buffer is empty after reset. A push that collides with a flush or a
    // branch squash is dropped and never written.
    always_ff @(posedge clk_i) begin
        if (!sync_reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_c[i]      <= 1'b0;
                mem_salida[i] <= '0;
                mem_branch[i] <= 1'b0;
            end
        end else if (push && !flush_i && !branch_squash) begin
            mem_c[wr_ptr]      <= c_i;
            mem_salida[wr_ptr] <= salida_i;
            mem_branch[wr_ptr] <= branch_flag_i;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_alu_result_fifo
//
// Purpose:
//   Directed self-checking bench for alu_result_fifo (DATA_W=32, DEPTH=4).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
//   unit after the following rising edge. Expected values are hand-computed
//   constants. Results that depend on BRANCH_FLUSH_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_alu_result_fifo;

    logic        clk;
    logic        sync_reset;
    logic        in_valid;
    logic        in_ready;
    logic        c_in;
    logic [31:0] salida_in;
    logic        branch_in;
    logic        out_valid;
    logic        out_ready;
    logic        c_out;
    logic [31:0] salida_out;
    logic        branch_out;
    logic        flush;
    logic [2:0]  count;
    logic        overflow;

    int check_count = 0;
    int error_count = 0;

    alu_result_fifo #(.DATA_W(32), .DEPTH(4)) dut (
        .clk_i         (clk),
        .sync_reset_i  (sync_reset),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .c_i           (c_in),
        .salida_i      (salida_in),
        .branch_flag_i (branch_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .c_o           (c_out),
        .salida_o      (salida_out),
        .branch_flag_o (branch_out),
        .flush_i       (flush),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and count the check.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then settle.
    task automatic applyStimulus(input logic v, input logic c, input logic [31:0] d,
                                 input logic br, input logic ordy, input logic fl);
        in_valid  = v;
        c_in      = c;
        salida_in = d;
        branch_in = br;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_vals [4];

    initial begin
        fill_vals[0] = 32'h11;
        fill_vals[1] = 32'h22;
        fill_vals[2] = 32'h33;
        fill_vals[3] = 32'h44;

        sync_reset = 1'b0;
        in_valid   = 1'b0;
        c_in       = 1'b0;
        salida_in  = '0;
        branch_in  = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;

        // Reset, with a push offered to confirm that reset takes priority.
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_count",     32'(count),     32'd0);
        checkOutput("reset_overflow",  32'(overflow),  32'd0);
        checkOutput("reset_salida",    salida_out,     32'h0);
        sync_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_count", 32'(count), 32'd0);

        // Fill the buffer while the consumer stalls.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, fill_vals[i], 1'b0, 1'b0, 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_head",  salida_out, 32'h11);
            checkOutput("fill_valid", 32'(out_valid), 32'd1);
        end
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("pre_overflow",  32'(overflow), 32'd0);

        // Offer 0x55 while full. It must be refused and must set overflow.
        applyStimulus(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set",   32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count),    32'd4);
        checkOutput("ovf_head",  salida_out,    32'h11);

        // Drain. In the first cycle 0x55 is still offered with the buffer full,
        // so only the pop takes effect.
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_head", salida_out, fill_vals[i]);
            applyStimulus((i == 0), 1'b0, 32'h55, 1'b0, 1'b1, 1'b0);
            checkOutput("drain_count", 32'(count), 32'(3 - i));
        end
        checkOutput("drain_empty",     32'(out_valid), 32'd0);
        checkOutput("ovf_sticky",      32'(overflow),  32'd1);

        // Prime two entries, then stream push+pop for 10 cycles.
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h101, 1'b0, 1'b0, 1'b0);
        checkOutput("stream_prime", 32'(count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stream_head", salida_out, 32'h100 + 32'(i));
            applyStimulus(1'b1, 1'b0, 32'h102 + 32'(i), 1'b0, 1'b1, 1'b0);
            checkOutput("stream_count", 32'(count), 32'd2);
        end
        checkOutput("stream_tail_head", salida_out, 32'h10A);

        // Bring the buffer to 3 entries, then flush with a same-cycle push.
        applyStimulus(1'b1, 1'b0, 32'h10C, 1'b0, 1'b0, 1'b0);
        checkOutput("preflush_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 1'b0, 32'h99, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_count",    32'(count),     32'd0);
        checkOutput("flush_valid",    32'(out_valid), 32'd0);
        checkOutput("flush_overflow", 32'(overflow),  32'd1);
        applyStimulus(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush_count", 32'(count), 32'd1);
        checkOutput("postflush_head",  salida_out, 32'h77);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("postflush_empty", 32'(count), 32'd0);

        // The entry carrying the branch flag is followed by two younger entries.
        applyStimulus(1'b1, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        checkOutput("br_count",  32'(count),      32'd3);
        checkOutput("br_head_c", 32'(c_out),      32'd1);
        checkOutput("br_head_f", 32'(branch_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_FLUSH_EN
        checkOutput("br_squash_count", 32'(count),     32'd0);
        checkOutput("br_squash_valid", 32'(out_valid), 32'd0);
`else
        checkOutput("br_pop_count", 32'(count),      32'd2);
        checkOutput("br_pop_head",  salida_out,      32'hB);
        checkOutput("br_pop_c",     32'(c_out),      32'd0);
        checkOutput("br_pop_f",     32'(branch_out), 32'd0);
`endif

        // A reset in the middle of the stream drops everything and clears overflow.
        applyStimulus(1'b1, 1'b0, 32'hEE, 1'b0, 1'b0, 1'b0);
        sync_reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0);
        checkOutput("midreset_count",    32'(count),     32'd0);
        checkOutput("midreset_overflow", 32'(overflow),  32'd0);
        checkOutput("midreset_valid",    32'(out_valid), 32'd0);
        checkOutput("midreset_salida",   salida_out,     32'h0);
        sync_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
